// File: rtl/ifu_sequencer_if.sv
// Handshake and control bundle between the IFU sequencer and its
// surroundings: instruction memory, ALU/execute stage and fetch unit.
interface ifu_sequencer_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       zero_flag;
  logic       alu_done;
  logic       alu_start;
  logic [3:0] alu_op;
  logic [3:0] imm_address;
  logic       write_enable;
  logic       jump;
  logic       beq_set;
  logic       bne_set;
  logic       call;
  logic       ret;
  logic       halted;
  logic [1:0] err_code;
  logic [2:0] state;

  // Sequencer side
  modport master (
    input  instr, instr_valid, zero_flag, alu_done,
    output alu_start, alu_op, imm_address,
    output write_enable, jump, beq_set, bne_set, call, ret,
    output halted, err_code, state
  );

  // Environment side (memory, execute stage, fetch unit)
  modport slave (
    output instr, instr_valid, zero_flag, alu_done,
    input  alu_start, alu_op, imm_address,
    input  write_enable, jump, beq_set, bne_set, call, ret,
    input  halted, err_code, state
  );
endinterface

// File: rtl/ifu_sequencer.sv
// Multi-cycle control sequencer for the 4-bit instruction fetch unit.
// FETCH -> DECODE -> (EXEC) -> ISSUE -> FETCH, with an absorbing HALT.
// Every output is decoded from registered state only.
module ifu_sequencer (
  input  logic             clk,
  input  logic             reset,
  ifu_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_WE, K_JMP, K_BEQ, K_BNE, K_CALL, K_RET
  } kind_t;

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] depth_q, depth_d;
  logic [1:0] err_q, err_d;
  logic       first_q, first_d;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      kind_q  <= K_WE;
      ir_q    <= '0;
      depth_q <= '0;
      err_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      ir_q    <= ir_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  // Next-state logic: decode, branch resolution, depth tracking
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    ir_d    = ir_q;
    depth_d = depth_q;
    err_d   = err_q;
    first_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_ISSUE;
        case (ir_q[7:4])
          4'h0: kind_d = K_WE;
          4'h8: kind_d = K_JMP;
          // Branch outcome is frozen here; zero_flag is not looked at again
          4'h9: kind_d = bus.zero_flag ? K_BEQ : K_WE;
          4'hA: kind_d = bus.zero_flag ? K_WE  : K_BNE;
          4'hB: begin
            if (depth_q != 4'hF) begin
              kind_d = K_CALL;
            end else begin
              state_d = S_HALT;
              err_d   = 2'b01;
            end
          end
          4'hC: begin
            if (depth_q != 4'h0) begin
              kind_d = K_RET;
            end else begin
              state_d = S_HALT;
              err_d   = 2'b10;
            end
          end
          4'hD, 4'hE: begin
            state_d = S_HALT;
            err_d   = 2'b11;
          end
          4'hF: begin
            state_d = S_HALT;
            err_d   = 2'b00;
          end
          default: begin
            // 0x1-0x7: ALU operation; first_q marks the first EXEC cycle
            state_d = S_EXEC;
            first_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (bus.alu_done) begin
          state_d = S_ISSUE;
          kind_d  = K_WE;
        end
      end
      S_ISSUE: begin
        state_d = S_FETCH;
        if (kind_q == K_CALL) depth_d = depth_q + 4'd1;
        if (kind_q == K_RET)  depth_d = depth_q - 4'd1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode from registers only
  always_comb begin
    bus.alu_start    = (state_q == S_EXEC) && first_q;
    bus.alu_op       = ir_q[7:4];
    bus.imm_address  = ir_q[3:0];
    bus.write_enable = (state_q == S_ISSUE) && (kind_q == K_WE);
    bus.jump         = (state_q == S_ISSUE) && (kind_q == K_JMP);
    bus.beq_set      = (state_q == S_ISSUE) && (kind_q == K_BEQ);
    bus.bne_set      = (state_q == S_ISSUE) && (kind_q == K_BNE);
    bus.call         = (state_q == S_ISSUE) && (kind_q == K_CALL);
    bus.ret          = (state_q == S_ISSUE) && (kind_q == K_RET);
    bus.halted       = (state_q == S_HALT);
    bus.err_code     = err_q;
    bus.state        = state_q;
  end

endmodule

// File: tb/tb_ifu_sequencer.sv
// Scoreboard bench for ifu_sequencer: stimulus pushes the expected
// pulse/halt events with their cycle; a negedge monitor pops and compares.
module tb_ifu_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifu_sequencer_if bus ();

  ifu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Event vector bits: {alu_start, we, jump, beq, bne, call, ret, halt_rise}
  localparam logic [7:0] V_START = 8'h80;
  localparam logic [7:0] V_WE    = 8'h40;
  localparam logic [7:0] V_JMP   = 8'h20;
  localparam logic [7:0] V_BEQ   = 8'h10;
  localparam logic [7:0] V_BNE   = 8'h08;
  localparam logic [7:0] V_CALL  = 8'h04;
  localparam logic [7:0] V_RET   = 8'h02;
  localparam logic [7:0] V_HALT  = 8'h01;

  typedef struct {
    logic [7:0] vec;
    logic [3:0] op;
    logic [3:0] imm;
    logic [1:0] err;
    int         cyc;
  } ev_t;

  ev_t  sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic halted_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse or HALT entry must match the head of the scoreboard
  always @(negedge clk) begin : mon
    logic [7:0] v;
    ev_t        e;
    v = {bus.alu_start, bus.write_enable, bus.jump, bus.beq_set, bus.bne_set,
         bus.call, bus.ret, bus.halted & ~halted_prev};
    halted_prev <= bus.halted;
    if (v != 8'h00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event vec=%b op=%h imm=%h err=%b cyc=%0d",
                 v, bus.alu_op, bus.imm_address, bus.err_code, cyc);
      end else begin
        e = sb.pop_front();
        if (v !== e.vec || bus.alu_op !== e.op || bus.imm_address !== e.imm ||
            bus.err_code !== e.err || cyc != e.cyc) begin
          errors++;
          $display("FAIL event got vec=%b op=%h imm=%h err=%b cyc=%0d expected vec=%b op=%h imm=%h err=%b cyc=%0d",
                   v, bus.alu_op, bus.imm_address, bus.err_code, cyc,
                   e.vec, e.op, e.imm, e.err, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] vec, input logic [3:0] op, input logic [3:0] imm,
                      input logic [1:0] err, input int c);
    ev_t e;
    e.vec = vec; e.op = op; e.imm = imm; e.err = err; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Present one instruction for one FETCH cycle; returns at the DECODE negedge
  task automatic fetch(input logic [7:0] ins, output int c0);
    @(negedge clk);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    c0              = cyc;
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  // Non-ALU instruction: one event two cycles after FETCH accepts it
  task automatic simple(input logic [7:0] ins, input logic [7:0] vec, input logic [1:0] err);
    int c0;
    fetch(ins, c0);
    push(vec, ins[7:4], ins[3:0], err, c0 + 2);
    to_cyc(c0 + 3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int c0;
    reset           = 1'b1;
    bus.instr       = 8'h00;
    bus.instr_valid = 1'b0;
    bus.zero_flag   = 1'b0;
    bus.alu_done    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 8'(bus.state), 8'd0);
    chk("reset_halt_err", {5'd0, bus.halted, bus.err_code}, 8'd0);
    chk("reset_pulses", {bus.alu_start, bus.write_enable, bus.jump, bus.beq_set,
                         bus.bne_set, bus.call, bus.ret, 1'b0}, 8'd0);
    chk("reset_ir", {bus.alu_op, bus.imm_address}, 8'h00);
    reset = 1'b0;

    // NOP: state 0,1,3,0 and one write_enable
    fetch(8'h00, c0);
    chk("nop_decode_state", 8'(bus.state), 8'd1);
    push(V_WE, 4'h0, 4'h0, 2'b00, c0 + 2);
    to_cyc(c0 + 2);
    chk("nop_issue_state", 8'(bus.state), 8'd3);
    to_cyc(c0 + 3);
    chk("nop_fetch_state", 8'(bus.state), 8'd0);

    // ALU op, alu_done four cycles after alu_start
    fetch(8'h35, c0);
    push(V_START, 4'h3, 4'h5, 2'b00, c0 + 2);
    to_cyc(c0 + 3);
    chk("alu_exec_wait_state", 8'(bus.state), 8'd2);
    chk("alu_op_held", {bus.alu_op, bus.imm_address}, 8'h35);
    to_cyc(c0 + 6);
    bus.alu_done = 1'b1;
    push(V_WE, 4'h3, 4'h5, 2'b00, c0 + 7);
    to_cyc(c0 + 7);
    bus.alu_done = 1'b0;
    chk("alu_issue_state", 8'(bus.state), 8'd3);
    to_cyc(c0 + 8);
    chk("alu_back_fetch", 8'(bus.state), 8'd0);

    // alu_done already high in DECODE and first EXEC cycle
    fetch(8'h1F, c0);
    bus.alu_done = 1'b1;
    push(V_START, 4'h1, 4'hF, 2'b00, c0 + 2);
    push(V_WE,    4'h1, 4'hF, 2'b00, c0 + 3);
    to_cyc(c0 + 3);
    bus.alu_done = 1'b0;
    to_cyc(c0 + 4);

    // Branches and jump
    bus.zero_flag = 1'b1; simple(8'h97, V_BEQ, 2'b00);
    bus.zero_flag = 1'b0; simple(8'h97, V_WE,  2'b00);
    bus.zero_flag = 1'b0; simple(8'hA2, V_BNE, 2'b00);
    bus.zero_flag = 1'b1; simple(8'hA2, V_WE,  2'b00);
    simple(8'h8C, V_JMP, 2'b00);

    // zero_flag flipped after DECODE must not change the decision
    bus.zero_flag = 1'b1;
    fetch(8'h95, c0);
    push(V_BEQ, 4'h9, 4'h5, 2'b00, c0 + 2);
    @(posedge clk); #1 bus.zero_flag = 1'b0;
    to_cyc(c0 + 3);
    fetch(8'hA9, c0);
    push(V_BNE, 4'hA, 4'h9, 2'b00, c0 + 2);
    @(posedge clk); #1 bus.zero_flag = 1'b1;
    to_cyc(c0 + 3);
    bus.zero_flag = 1'b0;

    // Call depth up to 15, one ret/call, then overflow
    do_reset();
    for (int i = 0; i < 15; i++) simple(8'hB4, V_CALL, 2'b00);
    simple(8'hC6, V_RET,  2'b00);
    simple(8'hB4, V_CALL, 2'b00);
    simple(8'hB4, V_HALT, 2'b01);
    chk("overflow_halt", {bus.state, bus.halted, bus.err_code, 2'b00}, {3'd4, 1'b1, 2'b01, 2'b00});

    // Ret underflow straight after reset
    do_reset();
    chk("reset_from_halt", {bus.state, bus.halted, bus.err_code, 2'b00}, 8'h00);
    simple(8'hC0, V_HALT, 2'b10);
    chk("underflow_err", 8'(bus.err_code), 8'd2);

    // Illegal opcode, then inputs wiggled while halted
    do_reset();
    simple(8'hD3, V_HALT, 2'b11);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt_frozen", {bus.state, bus.halted, bus.err_code, 2'b00}, {3'd4, 1'b1, 2'b11, 2'b00});
      chk("halt_ir_frozen", {bus.alu_op, bus.imm_address}, 8'hD3);
      bus.instr       = 8'h00;
      bus.instr_valid = ~bus.instr_valid;
      bus.alu_done    = ~bus.alu_done;
    end
    bus.instr_valid = 1'b0;
    bus.alu_done    = 1'b0;
    do_reset();
    simple(8'hE1, V_HALT, 2'b11);
    do_reset();
    simple(8'hF0, V_HALT, 2'b00);
    chk("hlt_state", {bus.state, bus.halted, bus.err_code, 2'b00}, {3'd4, 1'b1, 2'b00, 2'b00});

    // Reset while waiting for alu_done; depth must also clear
    do_reset();
    simple(8'hB1, V_CALL, 2'b00);
    fetch(8'h21, c0);
    push(V_START, 4'h2, 4'h1, 2'b00, c0 + 2);
    to_cyc(c0 + 3);
    reset        = 1'b1;
    bus.alu_done = 1'b1;
    @(negedge clk);
    chk("midop_reset_state", 8'(bus.state), 8'd0);
    chk("midop_reset_ir", {bus.alu_op, bus.imm_address}, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    bus.alu_done = 1'b0;
    chk("midop_stays_fetch", 8'(bus.state), 8'd0);
    simple(8'hC0, V_HALT, 2'b10);

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d pending expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
